load_extend_unit: RTL and testbench
===================================

// Module: load_extend_unit
// PURPOSE
//  Parametrised load-data extractor/extender for the pipelined MIPS datapath (MEM->WB).
//  - Selects a byte, halfword or word lane from a memory read word using the low address bits.
//  - Zero- or sign-extends the selected lane to DATA_W.
//  - Buffers results in a DEPTH-entry queue with valid/ready handshakes on both sides.
// PARAMETERS
//  DATA_W  32  datapath width; multiple of 16, >=32
//  DEPTH   2   result queue entries; power of 2, >=2
// PORTS
//  clk        in   1       single clock; all state updates on rising edge
//  reset      in   1       synchronous, active-high reset
//  in_valid   in   1       request valid
//  in_ready   out  1       unit can accept a request this cycle
//  in_data    in   DATA_W  raw memory read word, little-endian lanes
//  in_addr    in   2       byte offset, address[1:0]
//  in_size    in   2       00 byte, 01 half, 10 word, 11 reserved (treated as word)
//  in_signed  in   1       1 = sign-extend (lb/lh), 0 = zero-extend (lbu/lhu)
//  out_valid  out  1       result valid
//  out_ready  in   1       consumer accepts result
//  out_data   out  DATA_W  extended result
//  out_err    out  1       misalignment flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: count=0, rd_ptr=wr_ptr=0, out_valid=0, out_data=0, out_err=0, in_ready=1.
//  - Handshakes:
//    - push = in_valid & in_ready; pop = out_valid & out_ready.
//    - in_ready = (count != DEPTH). It depends only on state; there is no combinational path from out_ready.
//  - Lane select: byte lane = in_data[8*addr +: 8]; half lane = in_data[16*addr[1] +: 16].
//  - Word size: word = in_data[31:0]. For DATA_W>32 the word is also extended per in_signed.
//  - Extension: upper bits are filled with the lane MSB when in_signed=1, otherwise 0.
//  - Latency: a request pushed in cycle N is visible on out_* in cycle N+1 (queue empty case).
//    - No same-cycle bypass.
//  - Ordering: strict FIFO.
//  - Queue output: out_data and out_err are driven from entry rd_ptr; out_valid = (count != 0).
//  - Pointers wrap modulo DEPTH.
//  - Count update: push only -> +1; pop only -> -1; push & pop in the same cycle -> count unchanged.
//    Both entries are updated correctly, including when count==DEPTH-1.
//  - Full: in_ready=0, so an in_valid in that cycle is ignored.
//    A pop that cycle makes in_ready=1 in the following cycle.
//  - Empty: out_valid=0; out_data holds the stale entry value; the consumer must qualify with out_valid.
//  - Stall: while out_valid & !out_ready, out_data and out_err are held stable.
//  - Reset mid-operation: all queued results are discarded; state returns to the reset values next cycle.
//  - Out-of-range in_data when no push occurs is ignored; no X propagates into the queue.
// CONFIGURATION
//  Macro LOAD_ALIGN_CHECK_EN.
//  - Defined:
//    - Misalignment is a half access with addr[0]=1, or a word access with addr!=0.
//    - A misaligned request is still queued; its entry stores out_err=1 and out_data=0.
//  - Undefined:
//    - out_err is tied to 0.
//    - Half accesses ignore addr[0]; word accesses ignore addr.
//    - No entry storage is allocated for the error bit.
// STRUCTURE
//  - Package load_ext_pkg:
//    - SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10.
//    - typedef ld_size_t.
//    - function ptr width clog2(DEPTH).
//  - Sub-module load_ext_fifo: generic DATA_W+1 wide, DEPTH-entry synchronous FIFO (count and pointers).
//  - Top level: combinational lane select and extend feeding the FIFO, plus the optional alignment check.
// TESTING
//  1. Reset: assert reset 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, out_data=0 throughout.
//  2. Bytes: data=32'h80FF7F01, size=00.
//     - signed, addr=3 -> FFFFFF80 one cycle later.
//     - unsigned, addr=1 -> 0000007F.
//  3. Halves: data=32'h8001F00F, size=01.
//     - signed, addr=2 -> FFFF8001.
//     - unsigned, addr=0 -> 0000F00F.
//  4. Backpressure: out_ready=0 for 4 cycles with continuous in_valid.
//     - Exactly DEPTH pushes accepted, then in_ready=0.
//     - Release out_ready -> results drain in order, no loss or duplication.
//  5. Simultaneous events: at count=DEPTH-1, push and pop in the same cycle.
//     - count unchanged; order preserved across pointer wrap.
//  6. With LOAD_ALIGN_CHECK_EN: word at addr=2 -> out_err=1, out_data=0.
//     - Without the macro: same stimulus -> out_err=0, out_data=in_data.

Source files
------------

// File: rtl/load_extend_unit_pkg.sv
// Shared load-size encodings and sizing helpers for the MEM->WB load extend unit.
package load_ext_pkg;

    typedef logic [1:0] ld_size_t;

    localparam ld_size_t SIZE_BYTE = 2'b00;
    localparam ld_size_t SIZE_HALF = 2'b01;
    localparam ld_size_t SIZE_WORD = 2'b10;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/load_extend_unit_if.sv
// Request/result handshake bundle between the memory stage and the load extend unit.
interface load_extend_unit_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [1:0]        in_addr;
    logic [1:0]        in_size;
    logic              in_signed;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_err;

    modport master (
        output in_valid, in_data, in_addr, in_size, in_signed, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_data, in_addr, in_size, in_signed, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/load_extend_unit_fifo.sv
// Generic W-wide, DEPTH-entry synchronous FIFO; in_ready depends only on the fill count.
import load_ext_pkg::*;

module load_ext_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_entry,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_entry
);
    localparam int PW = ptr_w(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic          push;
    logic          pop;

    assign in_ready  = (count != (PW+1)'(DEPTH));
    assign out_valid = (count != '0);
    assign out_entry = mem[rd_ptr];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/load_extend_unit.sv
// Load lane select + zero/sign extend feeding a result FIFO (MEM->WB).
// Optional misalignment flagging is enabled by defining LOAD_ALIGN_CHECK_EN.
import load_ext_pkg::*;

module load_extend_unit #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input logic               clk,
    input logic               reset,
    load_extend_unit_if.slave bus
);
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       lane_w;
    logic [DATA_W-1:0] ext;

    assign lane_b = bus.in_data[{bus.in_addr, 3'b000} +: 8];
    assign lane_h = bus.in_data[{bus.in_addr[1], 4'b0000} +: 16];
    assign lane_w = bus.in_data[31:0];

    always_comb begin
        ext = '0;
        case (ld_size_t'(bus.in_size))
            SIZE_BYTE: begin
                ext       = {DATA_W{bus.in_signed & lane_b[7]}};
                ext[7:0]  = lane_b;
            end
            SIZE_HALF: begin
                ext       = {DATA_W{bus.in_signed & lane_h[15]}};
                ext[15:0] = lane_h;
            end
            default: begin
                ext       = {DATA_W{bus.in_signed & lane_w[31]}};
                ext[31:0] = lane_w;
            end
        endcase
    end

`ifdef LOAD_ALIGN_CHECK_EN
    localparam int ENTRY_W = DATA_W + 1;

    logic misalign;

    // Reserved size 2'b11 is a word access, so it shares the word alignment rule.
    always_comb begin
        misalign = 1'b0;
        case (ld_size_t'(bus.in_size))
            SIZE_BYTE: misalign = 1'b0;
            SIZE_HALF: misalign = bus.in_addr[0];
            default:   misalign = (bus.in_addr != 2'b00);
        endcase
    end

    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    assign wr_entry     = {misalign, misalign ? {DATA_W{1'b0}} : ext};
    assign bus.out_data = rd_entry[DATA_W-1:0];
    assign bus.out_err  = rd_entry[DATA_W];
`else
    localparam int ENTRY_W = DATA_W;

    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    assign wr_entry     = ext;
    assign bus.out_data = rd_entry;
    assign bus.out_err  = 1'b0;
`endif

    load_ext_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_entry  (wr_entry),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_entry (rd_entry)
    );

endmodule

// File: tb/tb_load_extend_unit.sv
// Directed self-checking bench for load_extend_unit (DATA_W=32, DEPTH=2).
module tb_load_extend_unit;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    load_extend_unit_if #(.DATA_W(DATA_W)) bus ();

    load_extend_unit #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [1:0] a,
                         input logic [1:0] s, input logic sg, input logic rdy);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_addr   = a;
        bus.in_size   = s;
        bus.in_signed = sg;
        bus.out_ready = rdy;
    endtask

    // One request into an empty queue; result visible one cycle later, then drained.
    task automatic single(input string tag, input logic [31:0] d, input logic [1:0] a,
                          input logic [1:0] s, input logic sg,
                          input logic [31:0] exp_d, input logic exp_e);
        drive(1'b1, d, a, s, sg, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 32'hxxxx_xxxx;
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_data"}, bus.out_data, exp_d);
        check({tag, "_err"}, 32'(bus.out_err), 32'(exp_e));
        @(negedge clk);
        check({tag, "_empty"}, 32'(bus.out_valid), 32'd0);
    endtask

    logic [31:0] expq[$];
    int          accepted;
    int          drained;
    logic [31:0] head;

    initial begin
        reset = 1'b1;
        drive(1'b1, 32'hDEAD_BEEF, 2'd0, 2'b10, 1'b0, 1'b0);

        // Reset held two cycles with in_valid asserted
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_out_valid", 32'(bus.out_valid), 32'd0);
            check("rst_in_ready", 32'(bus.in_ready), 32'd1);
            check("rst_out_data", bus.out_data, 32'd0);
            check("rst_out_err", 32'(bus.out_err), 32'd0);
        end
        reset = 1'b0;

        // Bytes
        single("b_s3", 32'h80FF_7F01, 2'd3, 2'b00, 1'b1, 32'hFFFF_FF80, 1'b0);
        single("b_u1", 32'h80FF_7F01, 2'd1, 2'b00, 1'b0, 32'h0000_007F, 1'b0);
        single("b_u3", 32'h80FF_7F01, 2'd3, 2'b00, 1'b0, 32'h0000_0080, 1'b0);
        single("b_s2", 32'h80FF_7F01, 2'd2, 2'b00, 1'b1, 32'hFFFF_FFFF, 1'b0);
        single("b_s0", 32'h80FF_7F01, 2'd0, 2'b00, 1'b1, 32'h0000_0001, 1'b0);
        // Halves
        single("h_s2", 32'h8001_F00F, 2'd2, 2'b01, 1'b1, 32'hFFFF_8001, 1'b0);
        single("h_u0", 32'h8001_F00F, 2'd0, 2'b01, 1'b0, 32'h0000_F00F, 1'b0);
        single("h_s0", 32'h8001_F00F, 2'd0, 2'b01, 1'b1, 32'hFFFF_F00F, 1'b0);
        // Word and reserved size
        single("w_s0", 32'h8765_4321, 2'd0, 2'b10, 1'b1, 32'h8765_4321, 1'b0);
        single("w_r0", 32'h1234_5678, 2'd0, 2'b11, 1'b0, 32'h1234_5678, 1'b0);

        // Misaligned word
`ifdef LOAD_ALIGN_CHECK_EN
        single("w_mis", 32'h1234_5678, 2'd2, 2'b10, 1'b0, 32'h0000_0000, 1'b1);
        single("h_mis", 32'h8001_F00F, 2'd1, 2'b01, 1'b1, 32'h0000_0000, 1'b1);
`else
        single("w_mis", 32'h1234_5678, 2'd2, 2'b10, 1'b0, 32'h1234_5678, 1'b0);
        single("h_a1", 32'h8001_F00F, 2'd1, 2'b01, 1'b1, 32'hFFFF_F00F, 1'b0);
`endif

        // Backpressure: four cycles of in_valid with out_ready low
        accepted = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.in_ready) begin
                accepted++;
                expq.push_back(32'h0000_0A00 + 32'(i));
            end
            drive(1'b1, 32'h0000_0A00 + 32'(i), 2'd0, 2'b10, 1'b0, 1'b0);
            @(negedge clk);
        end
        check("bp_accepted", 32'(accepted), 32'(DEPTH));
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        check("bp_stall_data", bus.out_data, 32'h0000_0A00);
        drive(1'b0, 32'h0, 2'd0, 2'b10, 1'b0, 1'b1);
        drained = 0;
        for (int t = 0; t < 10 && bus.out_valid; t++) begin
            head = (expq.size() != 0) ? expq.pop_front() : 32'hBAD0_BAD0;
            check("bp_drain", bus.out_data, head);
            drained++;
            @(negedge clk);
        end
        check("bp_drained", 32'(drained), 32'(DEPTH));
        check("bp_in_ready_after", 32'(bus.in_ready), 32'd1);

        // Simultaneous push and pop at count = DEPTH-1, across pointer wraps
        drive(1'b1, 32'h0000_0C00, 2'd0, 2'b10, 1'b0, 1'b0);
        @(negedge clk);
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 32'h0000_0C00 + 32'(k), 2'd0, 2'b10, 1'b0, 1'b1);
            check("sim_valid", 32'(bus.out_valid), 32'd1);
            check("sim_data", bus.out_data, 32'h0000_0C00 + 32'(k - 1));
            check("sim_in_ready", 32'(bus.in_ready), 32'd1);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("sim_last", bus.out_data, 32'h0000_0C05);
        @(negedge clk);
        check("sim_empty", 32'(bus.out_valid), 32'd0);

        // Reset mid-operation discards queued results
        drive(1'b1, 32'h5555_AAAA, 2'd0, 2'b10, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("mid_full", 32'(bus.in_ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_data", bus.out_data, 32'd0);
        check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        check("mid_rst_stay", 32'(bus.out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
